// File: rtl/kplic_arbiter_if.sv
// KPLIC arbiter bundle: gateway requests/priorities in, claim/complete strobes and results out.
// Combinational wiring only; no latency.
// No backpressure: every strobe is a single-cycle pulse consumed on the edge it is sampled.
interface kplic_arbiter_if #(
    parameter int INT_NUM = 16,
    parameter int PRI_W   = 3,
    parameter int ID_W    = 5
);
    logic [INT_NUM-1:0]       valid_int_req;
    logic [INT_NUM*PRI_W-1:0] int_priority;
    logic [PRI_W-1:0]         priority_threshold;
    logic                     claim_req;
    logic [ID_W-1:0]          claim_id;
    logic                     claim_valid;
    logic                     complete_req;
    logic [ID_W-1:0]          complete_id;
    logic [INT_NUM-1:0]       int_completion;
    logic [INT_NUM-1:0]       int_pending;
    logic                     ext_int_req;

    modport master (
        output valid_int_req, int_priority, priority_threshold,
        output claim_req, complete_req, complete_id,
        input  claim_id, claim_valid, int_completion, int_pending, ext_int_req
    );

    modport slave (
        input  valid_int_req, int_priority, priority_threshold,
        input  claim_req, complete_req, complete_id,
        output claim_id, claim_valid, int_completion, int_pending, ext_int_req
    );
endinterface

// File: rtl/kplic_arbiter.sv
// KPLIC priority arbiter with claim/complete handling and gateway completion pulses.
// Latency: request pulse -> pending same edge, ext_int_req next edge; claim/complete results one edge.
// No backpressure: claim and complete strobes are always accepted in the cycle they arrive.
module kplic_arbiter #(
    parameter int INT_NUM = 16,
    parameter int PRI_W   = 3,
    parameter int ID_W    = 5
) (
    input  logic           kplic_clk,
    input  logic           kplic_rstn,
    kplic_arbiter_if.slave bus
);
    logic [INT_NUM-1:0] pending;
    logic [INT_NUM-1:0] in_service;
    logic [INT_NUM-1:0] claim_hit;
    logic [INT_NUM-1:0] cmp_hit;
    logic [PRI_W-1:0]   src_pri [INT_NUM];
    logic [ID_W-1:0]    win_id;
    logic [PRI_W-1:0]   win_pri;
    logic [ID_W-1:0]    best_id;
    logic [PRI_W-1:0]   best_pri;
    logic [ID_W-1:0]    claim_id_q;
    logic               claim_valid_q;
    logic [INT_NUM-1:0] completion_q;

    for (genvar g = 0; g < INT_NUM; g++) begin : g_pri
        assign src_pri[g] = bus.int_priority[g*PRI_W +: PRI_W];
    end

    // Ascending scan with strict '>' keeps the lowest ID on priority ties.
    always_comb begin
        win_id  = '0;
        win_pri = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            if (pending[i] && (src_pri[i] != '0) &&
                (src_pri[i] > bus.priority_threshold) && (src_pri[i] > win_pri)) begin
                win_id  = ID_W'(i + 1);
                win_pri = src_pri[i];
            end
        end
    end

    // IDs 0 and above INT_NUM never match any slot, so they fall through as no-ops.
    always_comb begin
        claim_hit = '0;
        cmp_hit   = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            claim_hit[i] = bus.claim_req && (win_id == ID_W'(i + 1));
            cmp_hit[i]   = bus.complete_req && (bus.complete_id == ID_W'(i + 1)) && in_service[i];
        end
    end

    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            pending       <= '0;
            in_service    <= '0;
            best_id       <= '0;
            best_pri      <= '0;
            claim_id_q    <= '0;
            claim_valid_q <= 1'b0;
            completion_q  <= '0;
        end else begin
            // New request wins over a same-cycle claim; claim re-arms in_service after a complete.
            pending       <= (pending & ~claim_hit) | bus.valid_int_req;
            in_service    <= (in_service & ~cmp_hit) | claim_hit;
            best_id       <= win_id;
            best_pri      <= win_pri;
            claim_valid_q <= bus.claim_req;
            if (bus.claim_req) begin
                claim_id_q <= win_id;
            end
            completion_q  <= cmp_hit;
        end
    end

    assign bus.claim_id       = claim_id_q;
    assign bus.claim_valid    = claim_valid_q;
    assign bus.int_completion = completion_q;
    assign bus.int_pending    = pending;
    assign bus.ext_int_req    = (best_id != '0) && (best_pri != '0);
endmodule

// File: doc/kplic_arbiter.md
Name: kplic_arbiter

Overview:
Priority arbiter and claim/complete controller for the KPLIC.
- Collects one-cycle valid_int_req pulses from the per-source gateways into a pending vector.
- Selects the highest-priority pending source above the threshold and drives a single external interrupt request to the hart.
- Handles the claim read and complete write, and returns a one-cycle int_completion pulse to the matching gateway.

Parameters:
INT_NUM, 16, number of interrupt sources; source IDs are 1..INT_NUM, and ID 0 means "no interrupt".
PRI_W, 3, priority field width; priority 0 means the source never interrupts.
ID_W, 5, ID width; must satisfy 2^ID_W > INT_NUM.

Ports:
kplic_clk  in  1  kplic clock
kplic_rstn  in  1  kplic reset, asynchronous, active-low
valid_int_req  in  INT_NUM  gateway request pulses; bit i is source i+1
int_priority  in  INT_NUM*PRI_W  packed priorities; bits [i*PRI_W +: PRI_W] belong to source i+1
priority_threshold  in  PRI_W  only priorities strictly greater than this value interrupt
claim_req  in  1  one-cycle claim read strobe
claim_id  out  ID_W  claimed source ID, 0 if none
claim_valid  out  1  one-cycle pulse; claim_id is valid
complete_req  in  1  one-cycle completion write strobe
complete_id  in  ID_W  ID being completed
int_completion  out  INT_NUM  one-cycle completion pulses to the gateways; bit i is source i+1
int_pending  out  INT_NUM  pending vector, for register read-back
ext_int_req  out  1  external interrupt request to the core

Behaviour:
Reset:
- pending, in_service, claim_id, claim_valid, int_completion, best_id, best_pri and ext_int_req are all 0.
- Reset mid-claim or mid-complete drops all state. No pulse is emitted after reset is released.

Pending:
- pending[i] is set at the edge where valid_int_req[i]=1.
- pending[i] is cleared at the edge where source i+1 is claimed.
- If set and clear occur in the same cycle, set wins (no request is lost).

Eligibility and winner selection:
- A source is eligible when pending=1, priority!=0 and priority>priority_threshold.
- win_id (combinational) is the eligible source with the highest priority. Ties go to the lowest ID. If nothing is eligible, win_id=0.

Registered winner:
- best_id and best_pri are registered from win_id every cycle.
- ext_int_req = (best_id!=0), registered.
- Latency: a valid_int_req pulse sampled at edge N sets pending at N; ext_int_req rises at edge N+1.
- Threshold and priority changes are reflected one edge later.

Claim:
- On claim_req at edge N:
  - claim_id <= win_id (computed from the current pending, not best_id).
  - claim_valid <= 1 for exactly one cycle.
  - If win_id!=0: pending[win_id] is cleared and in_service[win_id] is set at N.
- If win_id=0: claim_id <= 0, claim_valid still pulses, and no state changes.
- ext_int_req re-evaluates at N+1.
- Back-to-back claims on consecutive cycles each return a distinct winner.

Complete:
- On complete_req at edge N with 1<=complete_id<=INT_NUM and in_service[complete_id]=1:
  - in_service[complete_id] is cleared.
  - int_completion[complete_id-1] <= 1 for exactly one cycle, high during cycle N+1.
- complete_id=0, complete_id>INT_NUM, or a not-in-service ID is silently ignored: no pulse, no state change.

Simultaneous claim and complete:
- Both are processed in the same cycle.
- If they target the same ID, the complete clears in_service first and the claim then sets it, so in_service ends at 1.

Width rules:
- Priority comparisons are unsigned, PRI_W bits.
- IDs are zero-extended to ID_W.

Test Plan:
1. Reset with all inputs 0 -> claim_id=0, claim_valid=0, int_completion=0, ext_int_req=0; claim_req returns claim_id=0 with claim_valid=1.
2. Source 3 has priority 5, threshold 2; pulse valid_int_req[2] -> int_pending=0x0004; ext_int_req=1 one edge later; claim_req -> claim_id=3, pending cleared, ext_int_req=0 next edge.
3. Sources 2 and 7 both at priority 4, source 5 at priority 6, all pending -> claims return 5, then 2, then 7; ext_int_req=0 after the third claim.
4. Threshold 4, source 1 at priority 4 pending -> ext_int_req stays 0 and claim returns 0; lower the threshold to 3 -> ext_int_req=1 after one edge; claim returns 1.
5. Claim source 6, then complete_req with complete_id=6 -> int_completion=0x0020 for exactly one cycle; a repeat complete of 6, plus completes of 0 and 17, produce no pulse.
6. Reset asserted while source 4 is in service and pending -> all outputs 0; after release, complete_id=4 produces no pulse.
